cpu_debug_cmd_sync: RTL and testbench
=====================================

# cpu_debug_cmd_sync

Parametrised system-clock-side command receiver for the CPU debug slave. Synchronises the JTAG-domain update strobes, captures each completed debug command (IR code plus shift-register word) into a small FIFO, and hands commands to the debug core over a valid/ready handshake. One-hot take-action and take-no-action pulses are decoded per IR code. Unlike the fixed single-register predecessor, it buffers back-to-back commands and flags overflow instead of silently overwriting.

## Interface
Parameters:
- SR_W, 38: shift-register and command data width.
- IR_W, 2: IR width; N_IR = 2**IR_W decode outputs.
- DEPTH, 4: command FIFO depth; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops per strobe, ≥2.
- ACT_BIT, 35: bit of the captured word selecting action (1) or no-action (0).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- vs_udr  in  1  update-DR level from the JTAG domain (asynchronous)
- vs_uir  in  1  update-IR level from the JTAG domain (asynchronous)
- ir_in  in  IR_W  current IR (quasi-static, stable while vs_udr is high)
- sr  in  SR_W  shift-register word (quasi-static, stable while vs_udr is high)
- cmd_valid  out  1  FIFO head valid
- cmd_ready  in  1  consumer accepts head
- cmd_ir  out  IR_W  head IR code
- jdo  out  SR_W  head data word
- take_action  out  N_IR  one-hot pulse on pop when jdo[ACT_BIT]=1
- take_no_action  out  N_IR  one-hot pulse on pop when jdo[ACT_BIT]=0
- ir_update  out  1  one-cycle pulse per synchronised vs_uir rising edge
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a command was dropped
- clear_overflow  in  1  clears overflow

## Operation
- Each strobe passes through an SYNC_STAGES flop chain, followed by a delay flop. The rising edge is detected as sync_out & ~sync_d.
- Arm counter: after reset, all edges are ignored for SYNC_STAGES+1 cycles. A strobe that is already high during reset must not produce a command or an ir_update.
- A udr edge pushes {ir_in, sr}, sampled on the push edge, into the FIFO.
- A uir edge pulses ir_update and pushes nothing.
- FIFO uses read/write pointers with an extra wrap bit. level = wptr − rptr. Full when level==DEPTH; empty when level==0.
- Pop occurs when cmd_valid & cmd_ready.
- take_action and take_no_action are combinational: pop & decode(cmd_ir) & (jdo[ACT_BIT] or its inverse). Both are zero when not popping.
- Push while full: if a pop occurs in the same cycle, the push is accepted. Otherwise the command is dropped and overflow is set.
- Push while empty: no bypass. The command appears the next cycle.
- clear_overflow has priority over a simultaneous set. overflow reads 0 the next cycle.
- cmd_ir and jdo reflect the FIFO head. Their value is don't-care when cmd_valid=0 but must not be X after reset.

## Timing
- Reset values: cmd_valid=0, cmd_ir=0, jdo=0, take_action=0, take_no_action=0, ir_update=0, level=0, overflow=0. Sync chains, delay flops and pointers are 0; the arm counter is loaded.
- Latency: vs_udr first sampled high at edge k → push at edge k+SYNC_STAGES → cmd_valid=1 after that edge.
- ir_update is high for the cycle between edges k+SYNC_STAGES−1 and k+SYNC_STAGES.
- Throughput: one push and one pop per cycle.
- vs_udr must stay high and low for at least SYNC_STAGES+1 cycles each; shorter pulses are unsupported.
- cmd_valid is held until popped. Head data is stable while cmd_valid & ~cmd_ready.
- Reset asserted mid-operation empties the FIFO, clears overflow and restarts the arm counter at the next clk edge.

## Structure
- Shared package cpu_debug_pkg holds:
  - IR code constants: IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2, IR_TRACECTRL=3.
  - Default SR_W and ACT_BIT.
  - A packed cmd_t {ir, data} used by the FIFO.
- Sub-module debug_sync_edge contains the synchroniser chain, delay flop and rising-edge output, parameterised by SYNC_STAGES. It is instantiated twice, for udr and uir.
- The FIFO storage is inline.

## Test plan
- Single command: ir_in=2, sr=38'h08_0000_1234 (bit 35=1), udr pulse of 4 cycles → cmd_valid after 2 cycles, jdo=38'h08_0000_1234. Pop gives take_action=4'b0100 for one cycle and take_no_action=0.
- No-action: ir_in=0, sr bit35=0 → pop gives take_no_action=4'b0001.
- Overflow: cmd_ready=0, 5 udr pulses with DEPTH=4 → level=4, overflow=1, FIFO contents are commands 1–4 in order. clear_overflow → overflow=0.
- Full plus pop: level=4, a push and a pop in the same cycle → level stays 4, overflow stays 0, the new command lands at the tail.
- Reset with udr high: assert reset_n=0 while vs_udr=1, release → no cmd_valid and no ir_update for 10 cycles. The next fresh pulse is captured normally.
- uir edge: vs_uir pulse → exactly one ir_update pulse and level unchanged.

Source files
------------

// File: rtl/cpu_debug_pkg.sv
// Shared CPU debug definitions: IR codes, default widths and the command record.
package cpu_debug_pkg;

  localparam int DEF_SR_W    = 38;
  localparam int DEF_IR_W    = 2;
  localparam int DEF_ACT_BIT = 35;

  localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEF_IR_W-1:0] ir;
    logic [DEF_SR_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/debug_sync_edge.sv
// Multi-flop synchroniser for a slow JTAG-domain level, with rising-edge detect.
module debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_sync_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/cpu_debug_cmd_sync.sv
// System-clock side of the debug slave: synchronised update strobes feed a small
// command FIFO drained over valid/ready, with per-IR action/no-action pop pulses.
module cpu_debug_cmd_sync
  import cpu_debug_pkg::*;
#(
  parameter int SR_W        = DEF_SR_W,
  parameter int IR_W        = DEF_IR_W,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ACT_BIT     = DEF_ACT_BIT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [SR_W-1:0]          jdo,
  output logic [2**IR_W-1:0]       take_action,
  output logic [2**IR_W-1:0]       take_no_action,
  output logic                     ir_update,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int N_IR  = 2**IR_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);

  // Same layout as cpu_debug_pkg::cmd_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] data;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             r_overflow;

  logic             w_udr_rise;
  logic             w_uir_rise;
  logic             w_armed;
  logic             w_push;
  logic             w_push_ok;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [AW:0]      w_level;
  entry_t           w_head;

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_udr),
    .o_rise  (w_udr_rise)
  );

  debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (vs_uir),
    .o_rise  (w_uir_rise)
  );

  // Edges produced by strobes already high during reset fall inside the arm window.
  assign w_armed   = (r_arm_cnt == '0);
  assign w_push    = w_udr_rise & w_armed;
  assign ir_update = w_uir_rise & w_armed;

  assign w_level   = r_wptr - r_rptr;
  assign w_full    = (w_level == (AW+1)'(DEPTH));
  assign w_empty   = (w_level == '0);
  assign w_pop     = ~w_empty & cmd_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);

  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign cmd_valid = ~w_empty;
  assign cmd_ir    = w_head.ir;
  assign jdo       = w_head.data;
  assign level     = w_level;
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_arm_cnt  <= ARM_W'(SYNC_STAGES + 1);
      r_overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt - 1'b1;
      end
      if (w_push_ok) begin
        r_mem[r_wptr[AW-1:0]] <= '{ir: ir_in, data: sr};
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (clear_overflow) begin
        r_overflow <= 1'b0;
      end else if (w_push & ~w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < N_IR; gi++) begin : g_decode
    assign take_action[gi]    = w_pop & (cmd_ir == IR_W'(gi)) &  jdo[ACT_BIT];
    assign take_no_action[gi] = w_pop & (cmd_ir == IR_W'(gi)) & ~jdo[ACT_BIT];
  end

endmodule

// File: tb/tb_cpu_debug_cmd_sync.sv
// Directed and randomised checks of cpu_debug_cmd_sync against a queue-based model.
module tb_cpu_debug_cmd_sync;

  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int ACT   = 35;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vs_udr;
  logic              vs_uir;
  logic [IR_W-1:0]   ir_in;
  logic [SR_W-1:0]   sr;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [SR_W-1:0]   jdo;
  logic [3:0]        take_action;
  logic [3:0]        take_no_action;
  logic              ir_update;
  logic [2:0]        level;
  logic              overflow;
  logic              clear_overflow;

  cpu_debug_cmd_sync #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(S), .ACT_BIT(ACT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_update      (ir_update),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int irupd_cnt = 0;

  // Model: queue of {ir, data}, sticky overflow, edges since reset, strobe high-run lengths.
  logic [IR_W+SR_W-1:0] q[$];
  bit m_ovf = 0;
  int n_edges = 0;
  int udr_run = 0;
  int uir_run = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a falling edge; check, clock once, update model.
  task automatic cycle();
    logic [IR_W+SR_W-1:0] head;
    bit pop, push, full, ovf_set;
    logic [3:0] ea, ena;
    #1;
    if (ir_update === 1'b1) irupd_cnt++;
    chk("cmd_valid", 64'(cmd_valid), 64'(q.size() != 0));
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("ir_update", 64'(ir_update), 64'(uir_run == S && n_edges + 1 >= S + 2));
    pop = (q.size() != 0) && cmd_ready;
    ea  = '0;
    ena = '0;
    if (q.size() != 0) begin
      head = q[0];
      chk("cmd_ir", 64'(cmd_ir), 64'(head[SR_W+:IR_W]));
      chk("jdo", 64'(jdo), 64'(head[SR_W-1:0]));
      if (pop) begin
        if (head[ACT]) ea  = 4'(1 << head[SR_W+:IR_W]);
        else           ena = 4'(1 << head[SR_W+:IR_W]);
        $display("pop ir=%0d jdo=%h act=%0b", head[SR_W+:IR_W], head[SR_W-1:0], head[ACT]);
      end
    end
    chk("take_action", 64'(take_action), 64'(ea));
    chk("take_no_action", 64'(take_no_action), 64'(ena));
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      m_ovf   = 0;
      n_edges = 0;
      udr_run = 0;
      uir_run = 0;
    end else begin
      n_edges++;
      push    = (udr_run == S) && (n_edges >= S + 2);
      full    = (q.size() == DEPTH);
      ovf_set = 0;
      if (pop) void'(q.pop_front());
      if (push) begin
        if (!full || pop) q.push_back({ir_in, sr});
        else ovf_set = 1;
      end
      if (clear_overflow) m_ovf = 0;
      else if (ovf_set)   m_ovf = 1;
      udr_run = vs_udr ? ((udr_run < S + 1) ? udr_run + 1 : udr_run) : 0;
      uir_run = vs_uir ? ((uir_run < S + 1) ? uir_run + 1 : uir_run) : 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_udr(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d,
                           input int hi, input bit pop_at_push);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    for (int i = 0; i < hi; i++) begin
      if (pop_at_push) cmd_ready = (i == S);
      cycle();
    end
    vs_udr = 1'b0;
    if (pop_at_push) cmd_ready = 1'b0;
    idle(S + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt0, udr_left, uir_left, ready_pct;
    reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; clear_overflow = 1'b0;
    @(posedge clk);
    @(negedge clk);
    idle(2);
    #1;
    chk("reset_cmd_ir", 64'(cmd_ir), 64'd0);
    chk("reset_jdo", 64'(jdo), 64'd0);
    reset_n = 1'b1;
    idle(6);

    // Single action command on IR_BREAK
    pulse_udr(2'd2, 38'h08_0000_1234, 4, 1'b0);
    #1;
    chk("single_jdo", 64'(jdo), 64'h08_0000_1234);
    cmd_ready = 1'b1;
    #1;
    chk("single_ta", 64'(take_action), 64'b0100);
    chk("single_tna", 64'(take_no_action), 64'd0);
    cycle();
    cmd_ready = 1'b0;
    idle(1);

    // No-action command on IR_OCIMEM
    pulse_udr(2'd0, 38'h00_0000_0055, 4, 1'b0);
    cmd_ready = 1'b1;
    #1;
    chk("noact_tna", 64'(take_no_action), 64'b0001);
    cycle();
    cmd_ready = 1'b0;

    // Overflow: five commands into a four-deep FIFO
    for (int i = 1; i <= 5; i++) pulse_udr(2'(i), 38'(i), S + 1, 1'b0);
    #1;
    chk("ovf_level", 64'(level), 64'd4);
    chk("ovf_flag", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    cycle();
    clear_overflow = 1'b0;
    #1;
    chk("ovf_cleared", 64'(overflow), 64'd0);
    cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("ovf_order", 64'(jdo), 64'(i));
      cycle();
    end
    cmd_ready = 1'b0;

    // Full FIFO with a push and a pop in the same cycle
    for (int i = 0; i < 4; i++) pulse_udr(2'd3, 38'h10 + 38'(i), S + 1, 1'b0);
    pulse_udr(2'd1, 38'h3f, 4, 1'b1);
    #1;
    chk("fullpop_level", 64'(level), 64'd4);
    chk("fullpop_ovf", 64'(overflow), 64'd0);
    cmd_ready = 1'b1;
    idle(3);
    #1;
    chk("fullpop_tail", 64'(jdo), 64'h3f);
    cycle();
    cmd_ready = 1'b0;

    // Reset while both strobes are high
    vs_udr = 1'b1; vs_uir = 1'b1; ir_in = 2'd1; sr = 38'h1_2345_6789;
    reset_n = 1'b0;
    idle(3);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("rst_hi_valid", 64'(cmd_valid), 64'd0);
      chk("rst_hi_irupd", 64'(ir_update), 64'd0);
      cycle();
    end
    vs_udr = 1'b0; vs_uir = 1'b0;
    idle(S + 2);
    pulse_udr(2'd3, 38'h2_aaaa_5555, 4, 1'b0);
    #1;
    chk("rst_hi_fresh", 64'(level), 64'd1);
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;

    // Update-IR strobe: one pulse, nothing queued
    cnt0 = irupd_cnt;
    vs_uir = 1'b1;
    idle(4);
    vs_uir = 1'b0;
    idle(S + 2);
    chk("uir_once", 64'(irupd_cnt - cnt0), 64'd1);
    chk("uir_level", 64'(level), 64'd0);

    // Randomised traffic with independent strobes, varying consumer rate, rare resets
    udr_left  = S + 1;
    uir_left  = S + 3;
    ready_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) ready_pct = int'($urandom_range(0, 100));
      udr_left--;
      if (udr_left <= 0) begin
        vs_udr = ~vs_udr;
        if (vs_udr) begin
          ir_in = 2'($urandom);
          sr    = 38'({$urandom, $urandom});
        end
        udr_left = int'($urandom_range(S + 1, S + 6));
      end
      uir_left--;
      if (uir_left <= 0) begin
        vs_uir   = ~vs_uir;
        uir_left = int'($urandom_range(S + 1, S + 8));
      end
      cmd_ready      = ($urandom_range(0, 99) < ready_pct);
      clear_overflow = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 699) == 0) begin
        reset_n  = 1'b0;
        udr_left = S + 4;
        uir_left = S + 4;
        cycle();
        cycle();
        c += 2;
        reset_n = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
